// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the shared single-ported RAM.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority with starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  ram_mem_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    logic i_aligned;
    logic d_aligned;
    logic i_win;

    assign i_aligned = (i_addr[1:0] == 2'b00);
    assign d_aligned = (d_addr[1:0] == 2'b00);

`ifdef MEM_ARB_RR_EN
    // last_d set means the data port took the most recent grant
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (i_gnt) begin
            last_d <= 1'b0;
        end else if (d_gnt) begin
            last_d <= 1'b1;
        end
    end

    assign i_win = last_d;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign i_win = (starve_cnt == LIMIT);
`endif

    // Grants are held low while reset is asserted so no access escapes
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        unique case (1'b1)
            rst_n && i_req && d_req: begin
                i_gnt = i_win;
                d_gnt = !i_win;
            end
            rst_n && i_req && !d_req: i_gnt = 1'b1;
            rst_n && !i_req && d_req: d_gnt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ram_addr       = '0;
        ram_write_data = '0;
        ram_mem_write  = 1'b0;
        if (i_gnt) begin
            ram_addr = {i_addr[ADDR_WIDTH-1:2], 2'b00};
        end else if (d_gnt) begin
            ram_addr       = {d_addr[ADDR_WIDTH-1:2], 2'b00};
            ram_write_data = d_wdata;
            ram_mem_write  = d_we && d_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= i_gnt;
            i_err    <= i_gnt && !i_aligned;
            i_rdata  <= (i_gnt && i_aligned) ? ram_read_data : '0;
            d_rvalid <= d_gnt;
            d_err    <= d_gnt && !d_aligned;
            d_rdata  <= (d_gnt && d_aligned && !d_we) ? ram_read_data : '0;
        end
    end

endmodule
